// File: rtl/hpm_event_serializer.sv
// hpm_event_serializer: turns multi-unit per-cycle event increments into single-unit pulses via saturating credit
module hpm_event_serializer #(
    parameter int HPM_NUM_EVENTS = 28,
    parameter int INC_WIDTH      = 2,
    parameter int PEND_WIDTH     = 6,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                               clk_i,
    input  logic                               rstn_i,
    input  logic [HPM_NUM_EVENTS*INC_WIDTH-1:0] events_inc_i,
    input  logic                               flush_i,
    input  logic                               clear_lost_i,
    output logic [HPM_NUM_EVENTS:1]            events_o,
    output logic                               busy_o,
    output logic [HPM_NUM_EVENTS:1]            lost_o,
    output logic [DROP_CNT_WIDTH-1:0]          drop_cnt_o
);
    localparam int PW = PEND_WIDTH + 1;
    localparam int SW = INC_WIDTH + $clog2(HPM_NUM_EVENTS + 1);
    localparam int CW = DROP_CNT_WIDTH + SW;
    localparam logic [PW-1:0] PMAX = {1'b0, {PEND_WIDTH{1'b1}}};
    localparam logic [CW-1:0] CMAX = CW'({DROP_CNT_WIDTH{1'b1}});
    logic [PEND_WIDTH-1:0]     pend_q [1:HPM_NUM_EVENTS];
    logic [PEND_WIDTH-1:0]     pend_d [1:HPM_NUM_EVENTS];
    logic [PW-1:0]             sum    [1:HPM_NUM_EVENTS];
    logic [HPM_NUM_EVENTS:1]   ovf;
    logic [HPM_NUM_EVENTS:1]   lost_d;
    logic [SW-1:0]             drop_sum;
    logic [CW-1:0]             cnt_sum;
    logic [DROP_CNT_WIDTH-1:0] drop_cnt_d;
    always_comb begin
        events_o = '0;
        busy_o   = 1'b0;
        ovf      = '0;
        sum      = '{default: '0};
        pend_d   = '{default: '0};
        drop_sum = '0;
        for (int e = 1; e <= HPM_NUM_EVENTS; e++) begin
            events_o[e] = (pend_q[e] != '0) && !flush_i;
            busy_o      = busy_o | (pend_q[e] != '0);
            sum[e]      = {1'b0, pend_q[e]} - PW'(events_o[e])
                        + PW'(events_inc_i[e*INC_WIDTH-1 -: INC_WIDTH]);
            ovf[e]      = !flush_i && (sum[e] > PMAX);
            pend_d[e]   = flush_i ? '0 : (ovf[e] ? PMAX[PEND_WIDTH-1:0] : sum[e][PEND_WIDTH-1:0]);
            drop_sum    = drop_sum + (ovf[e] ? SW'(sum[e] - PMAX) : '0);
        end
        // a clear in the same cycle as new drops wins over them
        lost_d     = clear_lost_i ? '0 : (lost_o | ovf);
        cnt_sum    = CW'(drop_cnt_o) + CW'(drop_sum);
        drop_cnt_d = clear_lost_i ? '0 : (cnt_sum > CMAX ? '1 : cnt_sum[DROP_CNT_WIDTH-1:0]);
    end
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            pend_q     <= '{default: '0};
            lost_o     <= '0;
            drop_cnt_o <= '0;
        end else begin
            pend_q     <= pend_d;
            lost_o     <= lost_d;
            drop_cnt_o <= drop_cnt_d;
        end
    end
endmodule

// File: tb/tb_hpm_event_serializer.sv
// tb_hpm_event_serializer: scoreboard bench for a default instance and a narrow (PEND 3, DROP_CNT 4) instance
module tb_hpm_event_serializer;
    typedef struct {
        logic [28:1] ev;
        logic        busy;
        logic [28:1] lost;
        int unsigned cnt;
    } exp_t;
    logic        clk = 1'b0;
    logic        rstn;
    logic [55:0] inc_a, inc_b;
    logic        flush_a, flush_b, clear_a, clear_b;
    logic [28:1] ev_a, ev_b, lost_a, lost_b;
    logic        busy_a, busy_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;
    exp_t        q[$];
    int          mp [2][1:28];
    logic [28:1] ml [2];
    int unsigned mc [2];
    int          errs = 0;
    int          checks = 0;
    always #5 clk = ~clk;
    hpm_event_serializer dut_a (
        .clk_i(clk), .rstn_i(rstn), .events_inc_i(inc_a), .flush_i(flush_a),
        .clear_lost_i(clear_a), .events_o(ev_a), .busy_o(busy_a), .lost_o(lost_a),
        .drop_cnt_o(cnt_a)
    );
    hpm_event_serializer #(.PEND_WIDTH(3), .DROP_CNT_WIDTH(4)) dut_b (
        .clk_i(clk), .rstn_i(rstn), .events_inc_i(inc_b), .flush_i(flush_b),
        .clear_lost_i(clear_b), .events_o(ev_b), .busy_o(busy_b), .lost_o(lost_b),
        .drop_cnt_o(cnt_b)
    );
    function automatic logic [55:0] inc1(int e, int v);
        logic [55:0] r = '0;
        r[e*2-1 -: 2] = 2'(v);
        return r;
    endfunction
    task automatic model_push(int k, logic fl);
        exp_t x;
        x.busy = 1'b0;
        for (int e = 1; e <= 28; e++) begin
            x.ev[e] = (mp[k][e] != 0) && !fl;
            x.busy  = x.busy | (mp[k][e] != 0);
        end
        x.lost = ml[k];
        x.cnt  = mc[k];
        q.push_back(x);
    endtask
    task automatic model_clock(int k, logic [55:0] inc, logic fl, logic cl, logic r);
        int pmax = (k == 0) ? 63 : 7;
        int unsigned cmax = (k == 0) ? 65535 : 15;
        int unsigned ds = 0;
        int s, em;
        if (!r) begin
            for (int e = 1; e <= 28; e++) mp[k][e] = 0;
            ml[k] = '0;
            mc[k] = 0;
        end else begin
            for (int e = 1; e <= 28; e++) begin
                em = (mp[k][e] != 0 && !fl) ? 1 : 0;
                s  = mp[k][e] - em + int'(inc[e*2-1 -: 2]);
                if (fl) mp[k][e] = 0;
                else if (s > pmax) begin
                    mp[k][e] = pmax;
                    ds += s - pmax;
                    ml[k][e] = 1'b1;
                end else mp[k][e] = s;
            end
            if (cl) begin
                ml[k] = '0;
                mc[k] = 0;
            end else mc[k] = (mc[k] + ds > cmax) ? cmax : mc[k] + ds;
        end
    endtask
    task automatic check(string tag, logic [28:1] ev, logic busy, logic [28:1] lost, int unsigned cnt);
        exp_t x;
        checks++;
        assert (q.size() != 0) else begin
            errs++;
            $error("FAIL %s_queue obs=empty exp=entry", tag);
        end
        if (q.size() != 0) begin
            x = q.pop_front();
            checks++;
            assert (ev === x.ev) else begin errs++; $error("FAIL %s_events obs=%h exp=%h", tag, ev, x.ev); end
            checks++;
            assert (busy === x.busy) else begin errs++; $error("FAIL %s_busy obs=%b exp=%b", tag, busy, x.busy); end
            checks++;
            assert (lost === x.lost) else begin errs++; $error("FAIL %s_lost obs=%h exp=%h", tag, lost, x.lost); end
            checks++;
            assert (cnt === x.cnt) else begin errs++; $error("FAIL %s_drop_cnt obs=%0d exp=%0d", tag, cnt, x.cnt); end
        end
    endtask
    task automatic dchk(string tag, int unsigned obs, int unsigned exp);
        checks++;
        assert (obs === exp) else begin errs++; $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp); end
    endtask
    task automatic cycle(logic [55:0] ia, logic [55:0] ib, logic fa = 0, logic fb = 0,
                         logic ca = 0, logic cb = 0, logic r = 1);
        inc_a = ia; inc_b = ib; flush_a = fa; flush_b = fb; clear_a = ca; clear_b = cb; rstn = r;
        model_push(0, fa);
        model_push(1, fb);
        @(negedge clk);
        check("a", ev_a, busy_a, lost_a, 32'(cnt_a));
        check("b", ev_b, busy_b, lost_b, 32'(cnt_b));
        @(posedge clk);
        model_clock(0, ia, fa, ca, r);
        model_clock(1, ib, fb, cb, r);
        #1;
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end
    initial begin
        for (int k = 0; k < 2; k++) begin
            for (int e = 1; e <= 28; e++) mp[k][e] = 0;
            ml[k] = '0;
            mc[k] = 0;
        end
        rstn = 0; inc_a = '0; inc_b = '0;
        flush_a = 0; flush_b = 0; clear_a = 0; clear_b = 0;
        repeat (2) @(posedge clk);
        #1;
        repeat (2) cycle('0, '0);
        // single burst of 3 on event 5
        cycle(inc1(5, 3), '0);
        repeat (5) cycle('0, '0);
        dchk("t1_busy_idle", 32'(busy_a), 0);
        dchk("t1_lost", 32'(lost_a), 0);
        // steady one unit per cycle on event 1
        repeat (10) cycle(inc1(1, 1), '0);
        repeat (2) cycle('0, '0);
        // narrow instance: saturating credit and drop counter
        repeat (5) cycle('0, inc1(2, 3));
        dchk("t3_drop_cnt", 32'(cnt_b), 4);
        dchk("t3_lost2", 32'(lost_b[2]), 1);
        repeat (7) cycle('0, inc1(2, 3));
        dchk("t5_drop_sat", 32'(cnt_b), 15);
        cycle('0, inc1(2, 3), 0, 0, 0, 1);
        dchk("t5_clear_cnt", 32'(cnt_b), 0);
        dchk("t5_clear_lost", 32'(lost_b), 0);
        cycle('0, inc1(2, 3));
        dchk("t5_redrop", 32'(cnt_b), 2);
        repeat (9) cycle('0, '0);
        // flush one cycle after a burst on events 1 and 28
        cycle(inc1(1, 2) | inc1(28, 2), '0);
        cycle(inc1(1, 2) | inc1(28, 2), '0, 1);
        repeat (4) cycle('0, '0);
        dchk("t4_busy", 32'(busy_a), 0);
        dchk("t4_drop_cnt", 32'(cnt_a), 0);
        // build pend=40 on event 3 then reset mid-drain
        repeat (20) cycle(inc1(3, 3), '0);
        cycle('0, '0);
        cycle('0, '0, 0, 0, 0, 0, 0);
        dchk("t6_busy", 32'(busy_a), 0);
        cycle('0, '0);
        cycle(inc1(3, 1), '0);
        repeat (3) cycle('0, '0);
        // mixed traffic with occasional flush/clear
        for (int i = 0; i < 30; i++)
            cycle({$urandom, $urandom}, {$urandom, $urandom},
                  $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
        repeat (70) cycle('0, '0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
